// File: rtl/dsm_multi.sv
// Multi-channel 1st/2nd-order delta-sigma modulator: CHANNELS signed PCM streams to 1-bit DSD at the tick rate.
// Latency: y/y_valid update one cycle after each tick; an accepted sample is used at the first later tick.
// Backpressure: single holding register; pcm_ready is registered and low while a sample waits for a tick.
module dsm_multi #(
  parameter int PCM_QUANT  = 16,
  parameter int CHANNELS   = 2,
  parameter int GUARD      = 4,
  parameter int OVL_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick,
  input  logic [CHANNELS*PCM_QUANT-1:0] pcm_in,
  input  logic                          pcm_valid,
  output logic                          pcm_ready,
  input  logic                          order,
  input  logic                          mute,
  input  logic                          ovl_clear,
  output logic [CHANNELS-1:0]           y,
  output logic                          y_valid,
  output logic [CHANNELS-1:0]           overload
);

  localparam int ACC_W = PCM_QUANT + GUARD;
  localparam int SUM_W = ACC_W + 2;
  localparam int CNT_W = $clog2(OVL_CYCLES + 1);
  localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'((64'sd1 <<< (ACC_W - 1)) - 64'sd1);
  localparam logic signed [SUM_W-1:0] ACC_MIN = ~ACC_MAX;
  localparam logic signed [ACC_W-1:0] FB_POS  = ACC_W'((64'sd1 <<< (PCM_QUANT - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] FB_NEG  = -FB_POS;

  function automatic logic signed [ACC_W-1:0] sat(input logic signed [SUM_W-1:0] s);
    if (s > ACC_MAX) return ACC_MAX[ACC_W-1:0];
    if (s < ACC_MIN) return ACC_MIN[ACC_W-1:0];
    return s[ACC_W-1:0];
  endfunction

  function automatic logic clipped(input logic signed [SUM_W-1:0] s);
    return (s > ACC_MAX) || (s < ACC_MIN);
  endfunction

  logic [CHANNELS*PCM_QUANT-1:0] hold_q, active_q, sample;
  logic                          hold_full, ready_q, prev_order, accept, clr;
  logic signed [ACC_W-1:0]       acc1_q [CHANNELS];
  logic signed [ACC_W-1:0]       acc2_q [CHANNELS];
  logic signed [ACC_W-1:0]       fb_q   [CHANNELS];
  logic signed [ACC_W-1:0]       acc1_d [CHANNELS];
  logic signed [ACC_W-1:0]       acc2_d [CHANNELS];
  logic signed [ACC_W-1:0]       fb_d   [CHANNELS];
  logic [CNT_W-1:0]              sat_q  [CHANNELS];
  logic [CNT_W-1:0]              sat_d  [CHANNELS];
  logic [CHANNELS-1:0]           bit_d, set_d;

  assign pcm_ready = ready_q;
  assign accept    = pcm_valid & ready_q;
  // A waiting sample is consumed by the tick that transfers it.
  assign sample    = hold_full ? hold_q : active_q;
  // An order change restarts the loop from zero state.
  assign clr       = order ^ prev_order;

  // Per-channel loop arithmetic for the current tick, including overload recovery.
  always_comb begin
    logic signed [PCM_QUANT-1:0] smp;
    logic signed [SUM_W-1:0]     in_s, a1, a2, f, s1, s2;
    logic signed [ACC_W-1:0]     n1, n2;
    logic                        clip;
    smp    = '0;
    in_s   = '0;
    a1     = '0;
    a2     = '0;
    f      = '0;
    s1     = '0;
    s2     = '0;
    n1     = '0;
    n2     = '0;
    clip   = 1'b0;
    acc1_d = '{default: '0};
    acc2_d = '{default: '0};
    fb_d   = '{default: '0};
    sat_d  = '{default: '0};
    bit_d  = '0;
    set_d  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      smp  = sample[c*PCM_QUANT +: PCM_QUANT];
      in_s = mute ? '0 : SUM_W'(smp);
      a1   = clr ? '0 : SUM_W'(acc1_q[c]);
      a2   = clr ? '0 : SUM_W'(acc2_q[c]);
      f    = clr ? '0 : SUM_W'(fb_q[c]);
      s1   = a1 + in_s + f;
      n1   = sat(s1);
      s2   = a2 + SUM_W'(n1) + f;
      n2   = order ? sat(s2) : n1;
      clip = clipped(s1) | (order & clipped(s2));
      sat_d[c] = clip ? sat_q[c] + 1'b1 : '0;
      if (sat_d[c] == CNT_W'(OVL_CYCLES)) begin
        acc1_d[c] = '0;
        acc2_d[c] = '0;
        fb_d[c]   = '0;
        sat_d[c]  = '0;
        set_d[c]  = 1'b1;
        bit_d[c]  = 1'b1;
      end else begin
        acc1_d[c] = n1;
        acc2_d[c] = n2;
        fb_d[c]   = n2[ACC_W-1] ? FB_POS : FB_NEG;
        bit_d[c]  = ~n2[ACC_W-1];
      end
    end
  end

  // Holding/active sample registers and the registered ready flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q    <= '0;
      active_q  <= '0;
      hold_full <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      if (accept) hold_q <= pcm_in;
      if (tick && hold_full) active_q <= hold_q;
      hold_full <= accept | (hold_full & ~tick);
      ready_q   <= ~(accept | (hold_full & ~tick));
    end
  end

  // Integrator, feedback and saturation-run state, advanced only on ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_order <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        acc1_q[c] <= '0;
        acc2_q[c] <= '0;
        fb_q[c]   <= '0;
        sat_q[c]  <= '0;
      end
    end else if (tick) begin
      prev_order <= order;
      for (int c = 0; c < CHANNELS; c++) begin
        acc1_q[c] <= acc1_d[c];
        acc2_q[c] <= acc2_d[c];
        fb_q[c]   <= fb_d[c];
        sat_q[c]  <= sat_d[c];
      end
    end
  end

  // DSD bits, valid pulse and sticky overload flags (a new set beats a clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      y        <= '0;
      y_valid  <= 1'b0;
      overload <= '0;
    end else begin
      y_valid  <= tick;
      if (tick) y <= bit_d;
      overload <= (overload & ~{CHANNELS{ovl_clear}}) | (set_d & {CHANNELS{tick}});
    end
  end

endmodule

// File: tb/tb_dsm_multi.sv
// Self-checking bench for dsm_multi: a default instance and a small-guard/short-overload instance.
// A spec-level model (queue for holding, longint clamped sums) is compared against both every cycle.
// Density table plus directed sequences cover handshake, same-cycle accept/tick, order switch, reset, overload.
module tb_dsm_multi;
  localparam int CH = 2;
  localparam int PQ = 16;
  localparam longint FS = 32767;

  logic clk = 1'b0, rst = 1'b1, tick = 1'b0, pcm_valid = 1'b0;
  logic order = 1'b0, mute = 1'b0, ovl_clear = 1'b0;
  logic [CH*PQ-1:0] pcm_in = '0;
  logic rdy0, rdy1, yv0, yv1;
  logic [CH-1:0] y0, y1, ov0, ov1;

  int total_cnt = 0;
  int pass_cnt  = 0;
  bit chk_en    = 1'b0;

  always #5 clk = ~clk;

  dsm_multi #(.PCM_QUANT(PQ), .CHANNELS(CH), .GUARD(4), .OVL_CYCLES(64)) u_dut (
    .clk(clk), .rst(rst), .tick(tick), .pcm_in(pcm_in), .pcm_valid(pcm_valid),
    .pcm_ready(rdy0), .order(order), .mute(mute), .ovl_clear(ovl_clear),
    .y(y0), .y_valid(yv0), .overload(ov0));

  dsm_multi #(.PCM_QUANT(PQ), .CHANNELS(CH), .GUARD(1), .OVL_CYCLES(8)) u_ovl (
    .clk(clk), .rst(rst), .tick(tick), .pcm_in(pcm_in), .pcm_valid(pcm_valid),
    .pcm_ready(rdy1), .order(order), .mute(mute), .ovl_clear(ovl_clear),
    .y(y1), .y_valid(yv1), .overload(ov1));

  // ---------------- reference model ----------------
  typedef struct {
    longint a1;
    longint a2;
    longint fb;
    int     sat;
  } chst_t;

  chst_t            ms [2][CH];
  logic [CH-1:0]    m_y [2];
  logic [CH-1:0]    m_ovl [2];
  logic             m_yv = 1'b0, m_rdy = 1'b0, m_prev = 1'b0;
  logic [CH*PQ-1:0] m_act = '0;
  logic [CH*PQ-1:0] m_hold [$];

  function automatic longint clampv(input longint v, input int w);
    longint hi;
    hi = (longint'(1) <<< (w - 1)) - 1;
    if (v > hi) return hi;
    if (v < -hi - 1) return -hi - 1;
    return v;
  endfunction

  task automatic model_edge();
    logic [CH-1:0] ybits, setb;
    logic acc, clr, clip, b;
    longint x, t1, t2, n1, n2;
    int w, lim;
    chst_t s;
    if (rst) begin
      m_hold.delete();
      m_act = '0; m_prev = 1'b0; m_yv = 1'b0; m_rdy = 1'b0;
      for (int i = 0; i < 2; i++) begin
        for (int c = 0; c < CH; c++) begin
          ms[i][c].a1 = 0; ms[i][c].a2 = 0; ms[i][c].fb = 0; ms[i][c].sat = 0;
        end
        m_y[i] = '0; m_ovl[i] = '0;
      end
    end else begin
      acc = pcm_valid && m_rdy;
      clr = 1'b0;
      if (tick) begin
        if (m_hold.size() > 0) m_act = m_hold.pop_front();
        clr = (order != m_prev);
        m_prev = order;
      end
      for (int i = 0; i < 2; i++) begin
        w = (i == 0) ? 20 : 17;
        lim = (i == 0) ? 64 : 8;
        ybits = m_y[i];
        setb = '0;
        if (tick) begin
          for (int c = 0; c < CH; c++) begin
            s = ms[i][c];
            x = mute ? 0 : longint'($signed(m_act[c*PQ +: PQ]));
            if (clr) begin s.a1 = 0; s.a2 = 0; s.fb = 0; end
            t1 = s.a1 + x + s.fb;
            n1 = clampv(t1, w);
            clip = (t1 != n1);
            if (order) begin
              t2 = s.a2 + n1 + s.fb;
              n2 = clampv(t2, w);
              clip = clip || (t2 != n2);
            end else n2 = n1;
            b = (n2 >= 0);
            s.sat = clip ? s.sat + 1 : 0;
            if (s.sat == lim) begin
              s.a1 = 0; s.a2 = 0; s.fb = 0; s.sat = 0;
              setb[c] = 1'b1; ybits[c] = 1'b1;
            end else begin
              s.a1 = n1; s.a2 = n2; s.fb = b ? -FS : FS;
              ybits[c] = b;
            end
            ms[i][c] = s;
          end
        end
        m_y[i] = ybits;
        m_ovl[i] = (m_ovl[i] & ~{CH{ovl_clear}}) | setb;
      end
      if (acc) m_hold.push_back(pcm_in);
      m_yv = tick;
      m_rdy = (m_hold.size() == 0);
    end
  endtask

  always @(posedge clk) model_edge();

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic chk_range(input string nm, input int v, input int lo, input int hi);
    total_cnt++;
    if (v >= lo && v <= hi) pass_cnt++;
    else $display("FAIL %s: got %0d, want %0d..%0d", nm, v, lo, hi);
  endtask

  // Whole-output comparison of both instances against the model every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cycle_dut", {26'd0, y0, yv0, ov0, rdy0}, {26'd0, m_y[0], m_yv, m_ovl[0], m_rdy});
      chk("cycle_ovl", {26'd0, y1, yv1, ov1, rdy1}, {26'd0, m_y[1], m_yv, m_ovl[1], m_rdy});
    end
  end

  task automatic tstep();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [CH*PQ-1:0] v);
    int n;
    n = 0;
    while (rdy0 !== 1'b1 && n < 32) begin tstep(); n++; end
    if (n >= 32) chk("load_timeout", {31'd0, rdy0}, 32'd1);
    pcm_in = v; pcm_valid = 1'b1;
    tstep();
    pcm_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; tstep();
    rst = 1'b0; tstep();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic signed [PQ-1:0] p0;
    logic signed [PQ-1:0] p1;
    logic ord;
    logic mu;
    int   n;
    int   lo0, hi0, lo1, hi1;
  } row_t;

  row_t rows [4];

  initial begin
    int ones0, ones1, p;
    bit found;
    rows[0] = '{16'sd0,     16'sd0,      1'b1, 1'b0, 1024, 510,  514,  510,  514};
    rows[1] = '{16'sd16384, -16'sd16384, 1'b1, 1'b0, 4096, 3064, 3080, 1016, 1032};
    rows[2] = '{16'sd16384, 16'sd16384,  1'b0, 1'b0, 4096, 3032, 3112, 3032, 3112};
    rows[3] = '{16'sd16384, -16'sd16384, 1'b0, 1'b1, 1024, 510,  514,  510,  514};

    // Reset state
    rst = 1'b1;
    tstep();
    chk_en = 1'b1;
    chk("reset_state", {28'd0, y0, yv0, rdy0, ov0[0]}, 32'd0);
    chk("reset_ovl_flags", {30'd0, ov0 | ov1}, 32'd0);
    rst = 1'b0;
    tstep();
    chk("ready_after_reset", {31'd0, rdy0}, 32'd1);

    // Density table: tick every cycle, count ones per channel
    for (int r = 0; r < 4; r++) begin
      tick = 1'b0;
      order = rows[r].ord;
      mute = rows[r].mu;
      load({rows[r].p1, rows[r].p0});
      ones0 = 0; ones1 = 0;
      for (int k = 0; k < rows[r].n; k++) begin
        tick = 1'b1;
        tstep();
        if (r == 0 && k == 0) chk("idle_first_y", {29'd0, y0, yv0}, 32'd7);
        if (yv0) begin ones0 += int'(y0[0]); ones1 += int'(y0[1]); end
      end
      tick = 1'b0;
      chk_range($sformatf("density_r%0d_ch0", r), ones0, rows[r].lo0, rows[r].hi0);
      chk_range($sformatf("density_r%0d_ch1", r), ones1, rows[r].lo1, rows[r].hi1);
      if (r == 0) chk("idle_no_overload", {30'd0, ov0}, 32'd0);
    end

    // Handshake: valid held high, tick every 8 cycles
    mute = 1'b0;
    tstep();
    for (int i = 0; i < 18; i++) begin
      chk($sformatf("hs_ready_%0d", i), {31'd0, rdy0}, (i == 0 || i == 8 || i == 16) ? 32'd1 : 32'd0);
      pcm_in = {16'(i * 300), 16'(i * 100)};
      pcm_valid = 1'b1;
      tick = (i % 8 == 7);
      tstep();
    end
    pcm_valid = 1'b0; tick = 1'b0;

    // Accept and tick in the same cycle with holding empty: old active sample used
    do_reset();
    order = 1'b0; mute = 1'b0;
    pcm_in = 32'h8000_8000; pcm_valid = 1'b1; tick = 1'b1;
    tstep();
    pcm_valid = 1'b0;
    chk("acc_tick_first", {29'd0, y0, yv0}, 32'd7);
    chk("acc_tick_hold_full", {31'd0, rdy0}, 32'd0);
    tstep();
    tick = 1'b0;
    chk("acc_tick_second", {30'd0, y0}, 32'd0);

    // Order switch under mute: first bit from zero state
    for (int k = 0; k < 5; k++) begin tick = 1'b1; tstep(); end
    mute = 1'b1; order = 1'b1; tick = 1'b1;
    tstep();
    chk("switch_to2_y_dut", {30'd0, y0}, 32'd3);
    chk("switch_to2_y_ovl", {30'd0, y1}, 32'd3);
    for (int k = 0; k < 7; k++) tstep();
    order = 1'b0;
    tstep();
    tick = 1'b0;
    chk("switch_to1_y_dut", {30'd0, y0}, 32'd3);

    // Reset while a sample sits in holding
    mute = 1'b0;
    load(32'h1234_4321);
    chk("mid_hold_full", {31'd0, rdy0}, 32'd0);
    rst = 1'b1;
    tstep();
    chk("rst_ready_low", {31'd0, rdy0}, 32'd0);
    chk("rst_outputs", {27'd0, y0, yv0, ov0}, 32'd0);
    rst = 1'b0;
    tstep();
    chk("rst_ready_high", {31'd0, rdy0}, 32'd1);
    pcm_in = '0; tick = 1'b1;
    tstep();
    tick = 1'b0;
    chk("rst_first_y", {29'd0, y0, yv0}, 32'd7);

    // Overload on the small-guard instance, ch1 at negative full scale
    do_reset();
    order = 1'b1; mute = 1'b0; ovl_clear = 1'b0;
    load({-16'sd32768, 16'sd0});
    p = 0; found = 1'b0;
    while (!found && p < 1000) begin
      tick = 1'b1;
      tstep();
      p++;
      found = m_ovl[1][1];
    end
    chk("ovl_found", {31'd0, found}, 32'd1);
    chk("ovl_set_ch1", {31'd0, ov1[1]}, 32'd1);
    chk("ovl_ch0_quiet", {31'd0, ov1[0]}, 32'd0);
    chk("ovl_recovery_y", {31'd0, y1[1]}, 32'd1);
    ovl_clear = 1'b1;
    tstep();
    ovl_clear = 1'b0;
    chk("ovl_cleared", {31'd0, ov1[1]}, 32'd0);
    for (int j = 2; j <= p; j++) begin
      ovl_clear = (j == p);
      tstep();
    end
    ovl_clear = 1'b0; tick = 1'b0;
    chk("ovl_set_beats_clear", {31'd0, ov1[1]}, 32'd1);

    // Randomised traffic against the model
    for (int n = 0; n < 3000; n++) begin
      tick = ($urandom_range(0, 3) != 0);
      pcm_valid = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 3) == 0) pcm_in = $urandom();
      else for (int c = 0; c < CH; c++) pcm_in[c*PQ +: PQ] = 16'($urandom_range(0, 40000) - 20000);
      if ($urandom_range(0, 199) == 0) order = ~order;
      if ($urandom_range(0, 99) == 0) mute = ~mute;
      ovl_clear = ($urandom_range(0, 29) == 0);
      rst = ($urandom_range(0, 499) == 0);
      tstep();
    end
    rst = 1'b0; tick = 1'b0; pcm_valid = 1'b0; ovl_clear = 1'b0;
    tstep();
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/dsm_multi.md
# dsm_multi

Parametrised multi-channel delta-sigma modulator: the successor to the fixed single-channel 2nd-order DSM. It converts `CHANNELS` signed PCM streams into 1-bit DSD streams at the oversampled `tick` rate. It adds a valid/ready sample input with a holding register, runtime 1st/2nd-order select, mute, saturating integrators with guard bits, and per-channel overload detection with automatic integrator recovery. It sits between the PCM interpolator and the DSD output pins.

## Interface
- `PCM_QUANT`, default 16: PCM sample width (signed). FS = 2^(PCM_QUANT-1)-1.
- `CHANNELS`, default 2: number of independent modulators.
- `GUARD`, default 4: integrator guard bits. ACC_W = PCM_QUANT+GUARD.
- `OVL_CYCLES`, default 64: consecutive saturated ticks that trigger overload recovery.

Ports:
- `clk`  in  1  system clock (CLK_FREQ).
- `rst`  in  1  synchronous reset, active-high.
- `tick`  in  1  modulator advance strobe, one cycle per output bit.
- `pcm_in`  in  CHANNELS*PCM_QUANT  packed signed samples; channel c at bits [c*PCM_QUANT +: PCM_QUANT].
- `pcm_valid`  in  1  sample available.
- `pcm_ready`  out  1  holding register empty.
- `order`  in  1  0 = 1st order, 1 = 2nd order.
- `mute`  in  1  forces the modulator input to 0.
- `ovl_clear`  in  1  clears the sticky `overload` flags.
- `y`  out  CHANNELS  DSD bits.
- `y_valid`  out  1  1-cycle pulse, cycle after each tick.
- `overload`  out  CHANNELS  sticky per-channel overload flag.

## Operation
- Reset: acc1, acc2, fb, sat_cnt, active sample and holding register are cleared. Outputs `y`=0, `y_valid`=0, `overload`=0. `pcm_ready`=0 while `rst`=1, and 1 from the first cycle after.
- Input path: when `pcm_valid`&`pcm_ready`, `pcm_in` is written to the holding register and hold_full is set. `pcm_ready` = ~hold_full (registered, no combinational path from `pcm_valid`).
- Input transfer: on a tick with hold_full=1, holding moves to the active register and hold_full clears.
  - If an accept and a tick occur in the same cycle with hold_full=0, the new sample stays in holding and the tick uses the old active sample.
  - With no new sample, the active sample is held (zero-order hold).
- Per channel, per tick (all sums at ACC_W+2 bits, then saturated to [-2^(ACC_W-1), 2^(ACC_W-1)-1]):
  - in = mute ? 0 : active sample, sign-extended.
  - acc1' = sat(acc1 + in + fb).
  - acc2' = order ? sat(acc2 + acc1' + fb) : acc1'.
  - bit = (acc2' >= 0). fb' = bit ? -FS : +FS. y = bit.
- Saturation tracking: a tick where either sum clipped increments sat_cnt; an unclipped tick clears it.
- Overload recovery: when sat_cnt reaches OVL_CYCLES, that tick writes acc1=acc2=fb=0 and sat_cnt=0, sets `overload[c]`, and outputs y=1. Other channels are unaffected.
- `ovl_clear` clears all `overload` flags; a simultaneous set wins for that channel.
- Order change: `order` is sampled at every tick. If it differs from the previous tick's value, that tick zeroes acc1, acc2 and fb before computing, so the first bit is computed from the input alone.
- `mute` takes effect on the next tick. Integrators are not cleared.

## Timing
- Tick at cycle t: `y` and `y_valid` update at t+1. `y` holds between ticks.
- Sample accepted at cycle a: used at the first tick in a cycle > a. `pcm_ready` falls at a+1 and returns 1 cycle after the transferring tick.
- fb uses the previous tick's bit (1-tick feedback delay). After reset fb=0.
- Ticks on consecutive cycles are legal, including a tick every cycle.
- `rst` mid-operation discards holding and active samples. The first tick after reset behaves as after power-up.

## Test plan
- Idle: reset, order=2, pcm=0, tick every cycle for 1024 ticks → first y=1, ones count 512±2, `overload`=0.
- DC density: pcm ch0=+16384, ch1=-16384, 4096 ticks → ch0 ones 3072±8, ch1 ones 1024±8.
- Handshake: tick every 8 cycles, `pcm_valid` held high → `pcm_ready` falls the cycle after the accept and rises the cycle after the next tick; a second sample offered before that tick stalls. An accept in the same cycle as a tick with hold empty → sample first used one tick later.
- Overload: GUARD=1, OVL_CYCLES=8, order=2, ch1=-32768 constant → `overload[1]` sets and the integrators read zero the cycle after, `overload[0]` stays 0. Asserting `ovl_clear` in the same cycle as a new set → flag stays 1.
- Order switch and mute: toggle `order` mid-stream with mute=1 → first bit after the switch is 1 and integrators equal in+fb=0; 1st-order ones density at pcm=+16384 is 0.75±0.01.
- Reset mid-stream with hold_full=1 → after reset `pcm_ready`=1, `y`=0, and the next tick with pcm=0 gives y=1.
